// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial transmitter and receiver.
// Holds the FSM state encoding, frame geometry and the bit-period helper.
package serial_pkg;

    localparam int DataBits = 8;
    localparam int StopBits = 1;

    typedef enum logic [1:0] {
        sIdle     = 2'd0,
        sStartBit = 2'd1,
        sDataBit  = 2'd2,
        sStopBit  = 2'd3
    } serial_state_e;

    // Number of clocks per serial bit (integer division).
    function automatic int ticks_per_bit(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer: loadable down-counter that measures one serial bit period.
// oBitDone is high while the count sits at zero; the count never wraps.
module serial_bit_timer
    import serial_pkg::*;
#(
    parameter int Width = 4
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             iLoad,
    input  logic [Width-1:0] iLoadValue,
    output logic             oBitDone
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    // Next count: load wins, otherwise decrement until zero and hold there.
    always_comb begin
        count_d = count_q;
        if (iLoad) begin
            count_d = iLoadValue;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge, independent of block order.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign oBitDone = (count_q == '0);

endmodule

// File: rtl/serial_transmitter.sv
// serial_transmitter: UART transmitter, 8N1, LSB first, no flow control.
// Optional feature macro: SERIAL_TRANSMITTER_HOLD_EN adds a one-byte holding
// register so a second byte can be queued while a frame is on the line and
// frames go out back-to-back. Without it, oReady is high only in sIdle.
module serial_transmitter
    import serial_pkg::*;
#(
    parameter int ClockFrequency = 16000000,
    parameter int BaudRate       = 115200
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic [7:0] iData,
    input  logic       iSend,
    output logic       oReady,
    output logic       oBusy,
    output logic       oTXD
);

    localparam int TicksPerBit = ticks_per_bit(ClockFrequency, BaudRate);
    localparam int TimerWidth  = (TicksPerBit > 1) ? $clog2(TicksPerBit) : 1;
    localparam int IndexWidth  = $clog2(DataBits);
    localparam logic [TimerWidth-1:0] TimerReload = TimerWidth'(TicksPerBit - 1);
    localparam logic [IndexWidth-1:0] LastIndex   = IndexWidth'(DataBits - 1);

    if (TicksPerBit < 2) begin : g_bad_rate
        $error("serial_transmitter: TicksPerBit must be at least 2");
    end

    serial_state_e         state_q, state_d;
    logic [DataBits-1:0]   shift_q, shift_d;
    logic [IndexWidth-1:0] index_q, index_d;
    logic                  txd_q, txd_d;
    logic                  timer_load;
    logic                  bit_done;
    logic                  accept;

`ifdef SERIAL_TRANSMITTER_HOLD_EN
    logic [DataBits-1:0]   hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
`endif

    serial_bit_timer #(
        .Width (TimerWidth)
    ) u_bit_timer (
        .iClock     (iClock),
        .iReset     (iReset),
        .iLoad      (timer_load),
        .iLoadValue (TimerReload),
        .oBitDone   (bit_done)
    );

`ifdef SERIAL_TRANSMITTER_HOLD_EN
    assign oReady = ~hold_full_q;
`else
    assign oReady = (state_q == sIdle);
`endif
    assign oBusy  = (state_q != sIdle);
    assign oTXD   = txd_q;
    assign accept = iSend & oReady;

    // Next-state logic for the frame FSM, shift register and bit index.
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        index_d    = index_q;
        timer_load = 1'b0;
`ifdef SERIAL_TRANSMITTER_HOLD_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`endif
        unique case (state_q)
            sIdle: begin
                if (accept) begin
                    shift_d    = iData;
                    timer_load = 1'b1;
                    state_d    = sStartBit;
                end
            end
            sStartBit: begin
                if (bit_done) begin
                    index_d    = '0;
                    timer_load = 1'b1;
                    state_d    = sDataBit;
                end
            end
            sDataBit: begin
                if (bit_done) begin
                    shift_d    = shift_q >> 1;
                    timer_load = 1'b1;
                    if (index_q == LastIndex) begin
                        state_d = sStopBit;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            sStopBit: begin
                if (bit_done) begin
                    state_d = sIdle;
`ifdef SERIAL_TRANSMITTER_HOLD_EN
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        timer_load  = 1'b1;
                        state_d     = sStartBit;
                    end else if (accept) begin
                        shift_d    = iData;
                        timer_load = 1'b1;
                        state_d    = sStartBit;
                    end
`endif
                end
            end
            default: state_d = sIdle;
        endcase
`ifdef SERIAL_TRANSMITTER_HOLD_EN
        // A byte accepted mid-frame is queued, unless the stop bit is ending
        // with an empty hold, in which case it went straight to the shifter.
        if (accept && (state_q != sIdle) &&
            !((state_q == sStopBit) && bit_done && !hold_full_q)) begin
            hold_d      = iData;
            hold_full_d = 1'b1;
        end
`endif
    end

    // Line level for the current state; registered below so oTXD cannot glitch.
    always_comb begin
        txd_d = 1'b1;
        unique case (state_q)
            sStartBit: txd_d = 1'b0;
            sDataBit:  txd_d = shift_q[0];
            default:   txd_d = 1'b1;
        endcase
    end

    // Control registers with synchronous reset; reset aborts any frame.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= sIdle;
            index_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            txd_q   <= txd_d;
        end
    end

    // Datapath registers: contents only matter once a valid flag/state says so.
    // NOTE: shift and hold data are left unreset; only the control flags that
    // qualify them need a defined reset value.
    always_ff @(posedge iClock) begin
        shift_q <= shift_d;
`ifdef SERIAL_TRANSMITTER_HOLD_EN
        hold_q  <= hold_d;
`endif
    end

`ifdef SERIAL_TRANSMITTER_HOLD_EN
    // Hold-full flag: reset empties the holding register.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            hold_full_q <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
        end
    end
`endif

endmodule
